// File: rtl/sieve_controller_if.sv
// Host / BoolRam / populate-stage signal bundle for the sieve controller.
// The slave modport is the controller's view; master is the surrounding system.
interface sieve_controller_if #(
  parameter int BOOL_AW = 10
);
  logic               start;
  logic [BOOL_AW-1:0] max_prime;
  logic               bool_ram_q;
  logic               done_populating;
  logic [BOOL_AW-1:0] bool_ram_addr;
  logic               bool_ram_data;
  logic               bool_ram_wren;
  logic               bool_ram_sel;
  logic               pop_init;
  logic               populating;
  logic               busy;
  logic               done;

  modport master (
    output start, max_prime, bool_ram_q, done_populating,
    input  bool_ram_addr, bool_ram_data, bool_ram_wren, bool_ram_sel,
           pop_init, populating, busy, done
  );

  modport slave (
    input  start, max_prime, bool_ram_q, done_populating,
    output bool_ram_addr, bool_ram_data, bool_ram_wren, bool_ram_sel,
           pop_init, populating, busy, done
  );
endinterface

// File: rtl/sieve_controller.sv
// Prime sieve sequencer: clears BoolRam, marks composites for each base p with p*p <= max,
// then hands BoolRam to the populate stage and pulses done.
module sieve_controller #(
  parameter int BOOL_AW = 10,
  parameter int BASE_W  = 5
) (
  input logic               clk,
  input logic               reset,
  sieve_controller_if.slave bus
);
  localparam int MW = BOOL_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RD,
    S_EVAL,
    S_MARK,
    S_NXT,
    S_POP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BOOL_AW-1:0]  r_mx;
  logic [BOOL_AW-1:0]  r_addr;
  logic [BASE_W-1:0]   r_p;
  logic [MW-1:0]       r_m;
  logic                r_pop_init;

  logic [MW-1:0]       w_mx_ext;
  logic [MW-1:0]       w_p_sq;
  logic [MW-1:0]       w_p1_sq;
  logic [MW-1:0]       w_m_next;
  logic [BASE_W:0]     w_p1;

  // All base/multiple arithmetic is one bit wider than the RAM address so m+p and
  // (p+1)^2 never wrap when max_prime is at its ceiling.
  assign w_mx_ext = MW'(r_mx);
  assign w_p1     = {1'b0, r_p} + 1'b1;
  assign w_p_sq   = MW'(r_p) * MW'(r_p);
  assign w_p1_sq  = MW'(w_p1) * MW'(w_p1);
  assign w_m_next = r_m + MW'(r_p);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.max_prime < BOOL_AW'(2)) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_addr == r_mx) begin
          // First base is 2; if 4 > max there is nothing to mark.
          w_state_nxt = (w_mx_ext < MW'(4)) ? S_POP : S_RD;
        end
      end
      S_RD:    w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = bus.bool_ram_q ? S_NXT : S_MARK;
      S_MARK: begin
        if (w_m_next > w_mx_ext) begin
          w_state_nxt = S_NXT;
        end
      end
      S_NXT:   w_state_nxt = (w_p1_sq > w_mx_ext) ? S_POP : S_RD;
      S_POP: begin
        if (bus.done_populating) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mx       <= '0;
      r_addr     <= '0;
      r_p        <= '0;
      r_m        <= '0;
      r_pop_init <= 1'b0;
    end else begin
      r_pop_init <= (r_state == S_IDLE) && bus.start && (bus.max_prime >= BOOL_AW'(2));
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mx   <= bus.max_prime;
            r_addr <= '0;
          end
        end
        S_CLEAR: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == r_mx) begin
            r_p <= BASE_W'(2);
          end
        end
        S_EVAL: begin
          if (!bus.bool_ram_q) begin
            r_m <= w_p_sq;
          end
        end
        S_MARK: begin
          if (w_m_next <= w_mx_ext) begin
            r_m <= w_m_next;
          end
        end
        S_NXT:   r_p <= r_p + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.bool_ram_addr = '0;
    bus.bool_ram_data = 1'b0;
    bus.bool_ram_wren = 1'b0;
    bus.bool_ram_sel  = 1'b0;
    bus.populating    = 1'b0;
    bus.done          = 1'b0;
    bus.busy          = (r_state != S_IDLE);
    bus.pop_init      = r_pop_init;
    case (r_state)
      S_CLEAR: begin
        bus.bool_ram_addr = r_addr;
        bus.bool_ram_wren = 1'b1;
      end
      S_RD:    bus.bool_ram_addr = BOOL_AW'(r_p);
      S_MARK: begin
        bus.bool_ram_addr = r_m[BOOL_AW-1:0];
        bus.bool_ram_data = 1'b1;
        bus.bool_ram_wren = 1'b1;
      end
      S_POP: begin
        bus.bool_ram_sel = 1'b1;
        bus.populating   = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sieve_controller.sv
// Bench for sieve_controller: sieve-of-Eratosthenes write-sequence model, BoolRam model,
// directed runs covering small, degenerate, maximal, aborted and start-glitched sieves.
module tb_sieve_controller;
  logic clk;
  logic reset;

  sieve_controller_if #(.BOOL_AW(10)) bus ();

  sieve_controller #(.BOOL_AW(10), .BASE_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    bit          d;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks;
  int unsigned errors;
  int unsigned done_cnt;
  int unsigned popinit_cnt;
  int unsigned wren_cnt;
  int unsigned pop_cnt;
  int unsigned last_rd;
  bit          model_on;
  logic        ram [0:1023];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected BoolRam write stream: clear 0..mx, then multiples p*p, p*p+p, .. of each
  // still-unmarked base p with p*p <= mx.
  function automatic void build_expected(input int unsigned mx);
    bit comp [0:1023];
    exp_q.delete();
    if (mx < 2) return;
    for (int unsigned a = 0; a <= mx; a++) exp_q.push_back('{a, 1'b0});
    for (int unsigned p = 2; p * p <= mx; p++) begin
      if (!comp[p]) begin
        for (int unsigned m = p * p; m <= mx; m += p) begin
          comp[m] = 1'b1;
          exp_q.push_back('{m, 1'b1});
        end
      end
    end
  endfunction

  // Synchronous BoolRam, read data one cycle after address.
  always @(posedge clk) begin
    if (bus.bool_ram_wren) ram[bus.bool_ram_addr] <= bus.bool_ram_data;
    bus.bool_ram_q <= ram[bus.bool_ram_addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) done_cnt++;
      if (bus.pop_init) popinit_cnt++;
      if (bus.bool_ram_wren) wren_cnt++;
      if (bus.populating) pop_cnt++;
      if (bus.busy && !bus.bool_ram_wren && !bus.bool_ram_sel && bus.bool_ram_addr != 0)
        last_rd = bus.bool_ram_addr;
      if (model_on) begin
        check("wren_sel_excl", bus.bool_ram_wren & bus.bool_ram_sel, 0);
        check("populating_eq_sel", bus.populating, bus.bool_ram_sel);
        if (bus.bool_ram_wren) begin
          check("wr_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", bus.bool_ram_addr, e.a);
            check("wr_data", bus.bool_ram_data, e.d);
          end
        end
      end
    end
  end

  function automatic int unsigned outs_vec();
    return {bus.busy, bus.done, bus.bool_ram_wren, bus.bool_ram_sel, bus.populating,
            bus.pop_init, bus.bool_ram_data, bus.bool_ram_addr};
  endfunction

  task automatic run_sieve(input int unsigned mx, input bit glitch, input int unsigned pop_delay,
                           output int unsigned lat);
    int unsigned cyc;
    int unsigned d0;
    build_expected(mx);
    d0 = done_cnt;
    wren_cnt = 0;
    popinit_cnt = 0;
    pop_cnt = 0;
    last_rd = 0;
    bus.max_prime = 10'(mx);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.max_prime = 10'h3FF;
    cyc = 0;
    while (!bus.populating && !bus.done && cyc < 30000) begin
      if (glitch && cyc == 3) begin
        bus.start = 1'b1;
        bus.max_prime = 10'd500;
        bus.done_populating = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.done_populating = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.done_populating = 1'b0;
    lat = cyc;
    check("run_timeout", cyc < 30000, 1);
    if (bus.populating) begin
      for (int unsigned i = 0; i < pop_delay; i++) begin
        bus.start = glitch && (i == 0);
        bus.max_prime = 10'd7;
        @(negedge clk);
      end
      bus.start = 1'b0;
      check("pop_hold", bus.populating, 1);
      bus.done_populating = 1'b1;
      @(negedge clk);
      bus.done_populating = 1'b0;
      check("done_after_dp", bus.done, 1);
      check("pop_dropped", bus.populating, 0);
    end
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_after_run", bus.busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned lat;
    int unsigned zeros;
    int unsigned primes30 [10] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29};
    bit          is_p;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    model_on = 1'b1;
    for (int i = 0; i < 1024; i++) ram[i] = 1'b1;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.max_prime = '0;
    bus.done_populating = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 0);

    // T1: mx=30
    build_expected(30);
    check("model_len_30", exp_q.size(), 55);
    run_sieve(30, 1'b0, 3, lat);
    check("t1_wren_count", wren_cnt, 55);
    check("t1_pop_init", popinit_cnt, 1);
    check("t1_last_base", last_rd, 5);
    for (int unsigned i = 2; i <= 30; i++) begin
      is_p = 1'b0;
      foreach (primes30[k]) if (primes30[k] == i) is_p = 1'b1;
      check("t1_ram", ram[i], !is_p);
    end

    // T2: mx=3, no marking
    run_sieve(3, 1'b0, 2, lat);
    check("t2_wren_count", wren_cnt, 4);
    check("t2_no_rd", last_rd, 0);
    check("t2_pop_init", popinit_cnt, 1);

    // T3: mx=1, straight to done
    run_sieve(1, 1'b0, 0, lat);
    check("t3_latency", lat, 0);
    check("t3_no_pop_init", popinit_cnt, 0);
    check("t3_no_wren", wren_cnt, 0);
    check("t3_no_populating", pop_cnt, 0);

    // T4: mx=1023
    run_sieve(1023, 1'b0, 1, lat);
    check("t4_last_base", last_rd, 31);
    zeros = 0;
    for (int i = 2; i < 1024; i++) if (ram[i] == 1'b0) zeros++;
    check("t4_prime_count", zeros, 172);

    // T5: reset while marking multiples of 3 at mx=100
    build_expected(100);
    bus.max_prime = 10'd100;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!(bus.bool_ram_wren && bus.bool_ram_data && bus.bool_ram_addr == 10'd9) && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("t5_reach_mark3", lat < 2000, 1);
    reset = 1'b1;
    model_on = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs", outs_vec(), 0);
    reset = 1'b0;
    exp_q.delete();
    model_on = 1'b1;
    run_sieve(10, 1'b0, 2, lat);
    check("t5_wren_count", wren_cnt, 11 + 4 + 1);

    // T6: start (and done_populating) glitches outside IDLE are ignored
    run_sieve(20, 1'b1, 4, lat);
    check("t6_wren_count", wren_cnt, 34);
    check("t6_pop_init", popinit_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
